// File: rtl/std_mult_seq_if.sv
// Go/done handshake bundle for the sequential multiplier: operands and start
// request flow from master to slave, the registered product and done pulse return.
interface std_mult_seq_if #(
  parameter int width = 32
);
  logic             go;
  logic [width-1:0] left;
  logic [width-1:0] right;
  logic [width-1:0] out;
  logic             done;

  modport master (
    output go,
    output left,
    output right,
    input  out,
    input  done
  );

  modport slave (
    input  go,
    input  left,
    input  right,
    output out,
    output done
  );
endinterface

// File: rtl/std_mult_seq.sv
// Radix-2 shift-add unsigned multiplier producing a width-bit truncated product
// in a fixed width+1 cycles, using a single adder and a go/done handshake.
module std_mult_seq #(
  parameter int width = 32
) (
  input  logic           clk,
  input  logic           reset,
  std_mult_seq_if.slave  bus
);

  localparam int              cw         = $clog2(width + 1);
  localparam logic [cw-1:0]   last_count = cw'(width - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [width-1:0] mcand, mcand_next;
  logic [width-1:0] mplier, mplier_next;
  logic [width-1:0] acc, acc_next;
  logic [width-1:0] out_r, out_next;
  logic [cw-1:0]    count, count_next;
  logic             done_r, done_next;
  logic [width-1:0] sum;

  // Partial product for this iteration; the carry out of the top bit is dropped.
  assign sum = mplier[0] ? acc + mcand : acc;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    count_next  = count;
    out_next    = out_r;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.go) begin
          mcand_next  = bus.left;
          mplier_next = bus.right;
          acc_next    = '0;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (!bus.go) begin
          // Abort: partial result discarded, previous product stays visible.
          state_next = IDLE;
        end else begin
          acc_next    = sum;
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
          count_next  = count + cw'(1);
          if (count == last_count) begin
            out_next   = sum;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      count  <= count_next;
      out_r  <= out_next;
      done_r <= done_next;
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_std_mult_seq.sv
// Scoreboard bench for std_mult_seq: drivers push expected product and done cycle,
// per-instance monitors pop and compare on every done pulse (width 32 and width 4).
module tb_std_mult_seq;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;

  exp_t q32[$];
  exp_t q4[$];

  std_mult_seq_if #(.width(32)) b32 ();
  std_mult_seq_if #(.width(4))  b4 ();

  std_mult_seq #(.width(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  std_mult_seq #(.width(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (b32.done) begin
      check("w32_done_expected", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        exp_t e;
        e = q32.pop_front();
        check("w32_product", 64'(b32.out), 64'(e.prod));
        check("w32_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b4.done) begin
      check("w4_done_expected", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        exp_t e;
        e = q4.pop_front();
        check("w4_product", 64'(b4.out), 64'(e.prod));
        check("w4_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Start an op on the width-32 instance and wait for its done pulse.
  // chained: called in the done cycle of the previous op with go still high.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                       input bit chained, input bit keep_go, input bit scramble);
    exp_t e;
    bit   seen;
    if (!chained) @(negedge clk);
    b32.go    = 1'b1;
    b32.left  = a;
    b32.right = b;
    e.prod = prod;
    e.cyc  = cyc + (chained ? 2 : 1) + 32;
    q32.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b32.done) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        b32.left  = $urandom;
        b32.right = $urandom;
      end
    end
    check("w32_done_seen", 64'(seen), 64'd1);
    if (!keep_go) b32.go = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] prod);
    exp_t e;
    bit   seen;
    @(negedge clk);
    b4.go    = 1'b1;
    b4.left  = a;
    b4.right = b;
    e.prod = 32'(prod);
    e.cyc  = cyc + 1 + 4;
    q4.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b4.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("w4_done_seen", 64'(seen), 64'd1);
    b4.go = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    b32.go    = 1'b0;
    b32.left  = '0;
    b32.right = '0;
    b4.go     = 1'b0;
    b4.left   = '0;
    b4.right  = '0;

    #1;
    check("reset_out32", 64'(b32.out), 64'd0);
    check("reset_done32", 64'(b32.done), 64'd0);
    check("reset_out4", 64'(b4.out), 64'd0);
    check("reset_done4", 64'(b4.done), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Truncation, then a back-to-back op with go held through the done pulse.
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    run32(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run32(32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0);

    // Width-4 instance: wrap-around and zero operand with full latency.
    run4(4'd7, 4'd9, 4'd15);
    run4(4'd0, 4'd13, 4'd0);

    // Abort after E10: no done, previous product held.
    @(negedge clk);
    b32.go    = 1'b1;
    b32.left  = 32'd6;
    b32.right = 32'd7;
    repeat (11) @(negedge clk);
    b32.go = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_out_held", 64'(b32.out), 64'd15);
    check("abort_no_done", 64'(b32.done), 64'd0);
    run32(32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0);

    // Operands change every cycle while running.
    run32(32'd12, 32'd11, 32'd132, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between E5 and E6.
    @(negedge clk);
    b32.go    = 1'b1;
    b32.left  = 32'd100;
    b32.right = 32'd100;
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_out", 64'(b32.out), 64'd0);
    check("midrun_reset_done", 64'(b32.done), 64'd0);
    repeat (2) @(negedge clk);
    b32.go = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle_out", 64'(b32.out), 64'd0);
    run32(32'd100, 32'd100, 32'd10000, 1'b0, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check("w32_queue_drained", 64'(q32.size()), 64'd0);
    check("w4_queue_drained", 64'(q4.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
